// File: rtl/mul_mant_seq.sv
// Sequential radix-2 shift-add mantissa multiplier.
// Produces the unsigned SIZE_PROD-bit product of two SIZE_MANT-bit mantissas
// together with its leading-zero count, for use by the normalisation shifter.
// Latency is fixed at SIZE_MANT+1 edges from accept to o_valid.
module mul_mant_seq #(
    parameter int SIZE_MANT = 24,
    parameter int SIZE_PROD = 2 * SIZE_MANT,
    parameter int SIZE_LZC  = $clog2(SIZE_PROD)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_MANT-1:0] i_mant_a,
    input  logic [SIZE_MANT-1:0] i_mant_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_PROD-1:0] o_product,
    output logic [SIZE_LZC-1:0]  o_shift_number,
    output logic                 o_zero
);

    localparam int SIZE_CNT = $clog2(SIZE_MANT + 1);
    localparam logic [SIZE_CNT-1:0] LAST_STEP = SIZE_CNT'(SIZE_MANT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic                  ready_q,   ready_d;
    logic                  valid_q,   valid_d;
    logic [SIZE_PROD-1:0]  product_q, product_d;
    logic [SIZE_LZC-1:0]   shift_q,   shift_d;
    logic                  zero_q,    zero_d;
    logic [SIZE_PROD-1:0]  mcand_q,   mcand_d;
    logic [SIZE_MANT-1:0]  mplr_q,    mplr_d;
    logic [SIZE_PROD-1:0]  acc_q,     acc_d;
    logic [SIZE_CNT-1:0]   cnt_q,     cnt_d;

    // Leading zeros counted from the MSB; an all-zero value reports 0 so the
    // downstream shifter leaves a zero product untouched.
    function automatic logic [SIZE_LZC-1:0] count_lz(input logic [SIZE_PROD-1:0] value);
        logic [SIZE_LZC-1:0] n;
        logic                found;
        n     = '0;
        found = 1'b0;
        for (int i = SIZE_PROD - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + SIZE_LZC'(1);
                end
            end
        end
        if (!found) begin
            n = '0;
        end
        return n;
    endfunction

    // State, handshake, operand/accumulator and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            product_q <= '0;
            shift_q   <= '0;
            zero_q    <= 1'b0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            product_q <= product_d;
            shift_q   <= shift_d;
            zero_q    <= zero_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: accept, one shift-add step per BUSY edge, publish, hold.
    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        product_d = product_q;
        shift_d   = shift_q;
        zero_d    = zero_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                // o_ready comes up one edge after reset release and stays up here.
                ready_d = 1'b1;
                if (i_valid && ready_q) begin
                    mcand_d = SIZE_PROD'(i_mant_a);
                    mplr_d  = i_mant_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Product of two SIZE_MANT-bit values fits SIZE_PROD bits, so no carry out.
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + SIZE_CNT'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                product_d = acc_q;
                zero_d    = (acc_q == '0);
                shift_d   = count_lz(acc_q);
                valid_d   = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                // Result stays frozen until the consumer takes it; no accept on this edge.
                if (i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ready        = ready_q;
    assign o_valid        = valid_q;
    assign o_product      = product_q;
    assign o_shift_number = shift_q;
    assign o_zero         = zero_q;

endmodule

// File: tb/tb_mul_mant_seq.sv
// Bench for mul_mant_seq: directed operand vectors with literal expectations,
// plus a transaction-level model compared against the outputs every cycle.
module tb_mul_mant_seq;

    localparam int SM = 24;
    localparam int SP = 48;
    localparam int SL = 6;

    logic          i_clk;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [SM-1:0] i_mant_a;
    logic [SM-1:0] i_mant_b;
    logic          o_valid;
    logic          i_ready;
    logic [SP-1:0] o_product;
    logic [SL-1:0] o_shift_number;
    logic          o_zero;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mul_mant_seq #(.SIZE_MANT(SM)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_mant_a       (i_mant_a),
        .i_mant_b       (i_mant_b),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_product      (o_product),
        .o_shift_number (o_shift_number),
        .o_zero         (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference leading-zero count from the bit length of the product.
    function automatic int ref_lz(input logic [SP-1:0] p);
        int bl;
        logic [SP-1:0] v;
        v  = p;
        bl = 0;
        if (p == '0) return 0;
        while (v != '0) begin
            v = v >> 1;
            bl++;
        end
        return SP - bl;
    endfunction

    // Transaction model: accept -> countdown of SM+1 edges -> valid until taken.
    logic          m_ready;
    logic          m_valid;
    int            m_cnt;
    logic [SP-1:0] m_prod;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_ready <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (m_ready && i_valid) begin
            m_prod  <= SP'(i_mant_a) * SP'(i_mant_b);
            m_cnt   <= SM + 1;
            m_ready <= 1'b0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt   <= 0;
            m_valid <= 1'b1;
        end else if (m_valid && i_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end else if (!m_valid) begin
            m_ready <= 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge i_clk) begin
        chk("cmp_ready", 64'(o_ready), 64'(m_ready));
        chk("cmp_valid", 64'(o_valid), 64'(m_valid));
        if (m_valid) begin
            chk("cmp_product", 64'(o_product), 64'(m_prod));
            chk("cmp_shift", 64'(o_shift_number), 64'(ref_lz(m_prod)));
            chk("cmp_zero", 64'(o_zero), 64'(m_prod == '0));
        end
    end

    // Issue one operation, measure latency and check literal results.
    task automatic run_op(input logic [SM-1:0] a, input logic [SM-1:0] b,
                          input logic [SP-1:0] ep, input int es, input logic ez,
                          input string tag);
        int  n;
        bit  ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk({tag, "_ready_timeout"}, 64'(0), 64'(1));
            return;
        end
        i_valid  = 1'b1;
        i_mant_a = a;
        i_mant_b = b;
        @(posedge i_clk);
        #1;
        i_valid  = 1'b0;
        i_mant_a = SM'($urandom);
        i_mant_b = SM'($urandom);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge i_clk);
            n++;
            @(negedge i_clk);
            if (o_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk({tag, "_valid_timeout"}, 64'(0), 64'(1));
            return;
        end
        chk({tag, "_latency"}, 64'(n), 64'(SM + 1));
        chk({tag, "_product"}, 64'(o_product), 64'(ep));
        chk({tag, "_shift"}, 64'(o_shift_number), 64'(es));
        chk({tag, "_zero"}, 64'(o_zero), 64'(ez));
        chk({tag, "_model_prod"}, 64'(m_prod), 64'(ep));
        chk({tag, "_model_lz"}, 64'(ref_lz(m_prod)), 64'(es));
    endtask

    // Take the result on the next edge and check the handshake response.
    task automatic consume(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        chk({tag, "_valid_drop"}, 64'(o_valid), 64'(0));
        chk({tag, "_ready_rise"}, 64'(o_ready), 64'(1));
    endtask

    logic [SP-1:0] held_prod;
    logic [SL-1:0] held_shift;
    bit            saw_valid;

    initial begin
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_mant_a = '0;
        i_mant_b = '0;
        repeat (2) @(negedge i_clk);
        chk("rst_ready", 64'(o_ready), 64'(0));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_product", 64'(o_product), 64'(0));
        chk("rst_shift", 64'(o_shift_number), 64'(0));
        chk("rst_zero", 64'(o_zero), 64'(0));
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("rel_ready", 64'(o_ready), 64'(1));

        run_op(24'h800000, 24'h800000, 48'h400000000000, 1, 1'b0, "norm_min");
        consume("norm_min");
        run_op(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0, 1'b0, "max");
        consume("max");
        run_op(24'h000000, 24'h123456, 48'h0, 0, 1'b1, "zero");
        consume("zero");
        run_op(24'h000001, 24'h000001, 48'h1, 47, 1'b0, "one");

        // Backpressure: result held, new operands ignored.
        held_prod  = o_product;
        held_shift = o_shift_number;
        for (int k = 0; k < 10; k++) begin
            i_valid  = k[0];
            i_mant_a = 24'hABCDEF;
            i_mant_b = 24'h654321;
            @(negedge i_clk);
            chk("bp_ready", 64'(o_ready), 64'(0));
            chk("bp_valid", 64'(o_valid), 64'(1));
            chk("bp_product", 64'(o_product), 64'(held_prod));
            chk("bp_shift", 64'(o_shift_number), 64'(held_shift));
        end
        i_valid = 1'b0;
        consume("bp");
        run_op(24'h000003, 24'h000005, 48'hF, 44, 1'b0, "after_bp");
        consume("after_bp");

        // Reset during the 10th BUSY cycle.
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_mant_a = 24'hFFFFFF;
        i_mant_b = 24'hFFFFFF;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(o_ready), 64'(0));
        chk("mid_rst_valid", 64'(o_valid), 64'(0));
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        chk("mid_rel_ready_low", 64'(o_ready), 64'(0));
        @(posedge i_clk);
        #1;
        chk("mid_rel_ready_high", 64'(o_ready), 64'(1));
        saw_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_valid) saw_valid = 1'b1;
        end
        chk("aborted_never_valid", 64'(saw_valid), 64'(0));

        run_op(24'h800001, 24'h000003, 48'h000001800003, 23, 1'b0, "post_rst");
        consume("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
